// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready mux with a single registered output slot.
// mode=0 selects the channel on sel; mode=1 round-robins from the channel after
// the last one transferred. Optional 16-bit saturating transfer counter on
// xfer_cnt when RR_ARB_MUX_CNT_EN is defined.
module rr_arb_mux #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   grant
`ifdef RR_ARB_MUX_CNT_EN
  ,
  output logic [15:0]     xfer_cnt
`endif
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [SW-1:0] cand;
  logic          req;
  logic          load_en;
  logic          xfer;
  logic [W-1:0]  cand_data;

  // Candidate channel and its request, per mode.
  always_comb begin
    cand = '0;
    req  = 1'b0;
    if (!mode) begin
      cand = sel;
      // sel values outside 0..N-1 match nothing and leave req low.
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SW'(i)) req = in_valid[i];
      end
    end else begin
      req = |in_valid;
      // Walk the ring backwards so the closest channel after ptr wins.
      for (int unsigned k = N; k >= 1; k--) begin
        if (in_valid[(32'(ptr_q) + k) % N]) cand = SW'((32'(ptr_q) + k) % N);
      end
    end
  end

  // Per-channel ready, transfer strobe and candidate data.
  always_comb begin
    load_en   = (state_q == StEmpty) | out_ready;
    in_ready  = '0;
    cand_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand == SW'(i)) begin
        in_ready[i] = rst_n & load_en & req;
        cand_data   = in_data[i*W +: W];
      end
    end
    xfer = |in_ready;
  end

  // Next-state for the output slot and round-robin pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = StFull;
      data_d  = cand_data;
      grant_d = cand;
      ptr_d   = cand;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  // State registers; reset leaves channel 0 first in round-robin order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= SW'(N - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign grant     = grant_q;

`ifdef RR_ARB_MUX_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of input transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux (N=4, W=8): directed vector tables, hand sequences for
// backpressure/drain, and randomized traffic against a behavioural model.
module tb_rr_arb_mux;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;
  localparam int unsigned NW = N * W;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic [SW-1:0] sel;
  logic [NW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] grant;
`ifdef RR_ARB_MUX_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  rr_arb_mux #(.N(N), .W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant)
`ifdef RR_ARB_MUX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: contents of the output slot plus last-served channel.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_grant;
  int           m_ptr;
  int           m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel the rules say should be offered this cycle, or -1 if none.
  function automatic int m_cand();
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int off = 1; off <= N; off++) begin
      if (in_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_grant = 0;
    m_ptr   = N - 1;
    m_cnt   = 0;
  endtask

  // One clock: check ready before the edge, update model, check outputs after.
  task automatic step();
    int c;
    logic [N-1:0] exp_rdy;
    #1;
    c = m_cand();
    exp_rdy = '0;
    if (rst_n && (!m_valid || out_ready) && c >= 0) exp_rdy[c] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else if (exp_rdy != '0) begin
      m_valid = 1'b1;
      m_data  = in_data[c*W +: W];
      m_grant = c;
      m_ptr   = c;
      if (m_cnt < 65535) m_cnt++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("grant", 64'(grant), 64'(m_grant));
`ifdef RR_ARB_MUX_CNT_EN
    chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
`endif
    @(negedge clk);
  endtask

  typedef struct {
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  valid;
    logic [W-1:0]  exp_data;
    int            exp_grant;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [NW-1:0] nd;
    logic [W-1:0]  hold_d;
    logic [SW-1:0] hold_g;
    int            ng;

    // Fixed-mode steps followed by round-robin on channels 0,1,3.
    tbl[0] = '{1'b0, 2'd0, 4'hF,    8'h11, 0};
    tbl[1] = '{1'b0, 2'd1, 4'hF,    8'h22, 1};
    tbl[2] = '{1'b0, 2'd2, 4'hF,    8'h33, 2};
    tbl[3] = '{1'b0, 2'd3, 4'hF,    8'h44, 3};
    tbl[4] = '{1'b1, 2'd0, 4'b1011, 8'h11, 0};
    tbl[5] = '{1'b1, 2'd0, 4'b1011, 8'h22, 1};
    tbl[6] = '{1'b1, 2'd0, 4'b1011, 8'h44, 3};
    tbl[7] = '{1'b1, 2'd0, 4'b1011, 8'h11, 0};
    tbl[8] = '{1'b1, 2'd0, 4'b1011, 8'h22, 1};
    tbl[9] = '{1'b1, 2'd0, 4'b1011, 8'h44, 3};

    m_reset();
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset held two cycles with every channel valid.
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    rst_n = 1'b1;
    step();
    chk("first_grant_ch0", 64'(grant), 64'd0);

    // Directed table.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mode     = tbl[i].mode;
      sel      = tbl[i].sel;
      in_valid = tbl[i].valid;
      step();
      chk("tbl_data", 64'(out_data), 64'(tbl[i].exp_data));
      chk("tbl_grant", 64'(grant), 64'(tbl[i].exp_grant));
      chk("tbl_valid", 64'(out_valid), 64'd1);
    end

    // Backpressure: fill, stall 5 cycles with fresh inputs, then resume.
    mode     = 1'b1;
    in_valid = 4'hF;
    step();
    hold_d    = out_data;
    hold_g    = grant;
    nd        = 32'hA5B6C7D8;
    in_data   = nd;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", 64'(out_data), 64'(hold_d));
      chk("bp_hold_grant", 64'(grant), 64'(hold_g));
    end
    out_ready = 1'b1;
    step();
    ng = (int'(hold_g) + 1) % N;
    chk("bp_resume_grant", 64'(grant), 64'(ng));
    chk("bp_resume_data", 64'(out_data), 64'(nd[ng*W +: W]));

    // Drain then a single pulse on channel 2.
    in_valid = 4'b0000;
    step();
    chk("drain_bubble", 64'(out_valid), 64'd0);
    in_valid = 4'b0100;
    step();
    chk("pulse_valid", 64'(out_valid), 64'd1);
    chk("pulse_grant", 64'(grant), 64'd2);
    in_valid = 4'b0000;
    step();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      mode      = 1'($urandom());
      sel       = SW'($urandom());
      in_valid  = N'($urandom());
      in_data   = NW'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst_n = 1'b1;

`ifdef RR_ARB_MUX_CNT_EN
    // Long saturating run, then reset clears the counter.
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("cnt_saturated", 64'(xfer_cnt), 64'hFFFF);
    rst_n = 1'b0;
    step();
    chk("cnt_cleared", 64'(xfer_cnt), 64'd0);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
